// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared definitions for the programmable clock divider:
//   - state_t   : divider FSM states (IDLE, RUN, DRAIN)
//   - MIN_DIV   : smallest divisor that can produce a square wave
//   - DEF_WIDTH : default divisor width in bits
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int MIN_DIV   = 2;
   localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter
//   Period counter for the divider. Counts 0..N-1 while active, wraps after
//   N-1, flags the last cycle of each period and registers the divided output.
// Ports:
//   clk_in     in   clock, state updates on the rising edge
//   rst_in     in   asynchronous active-high reset
//   active     in   FSM is in RUN or DRAIN this cycle
//   active_nxt in   FSM will be in RUN or DRAIN after this edge
//   div_cur    in   divisor N of the period in progress
//   div_nxt    in   divisor N in effect after this edge
//   tick       out  high on the last cycle of a period (cnt == N-1)
//   div_out    out  registered divided square wave
module clk_div_counter
   import clk_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             active,
   input  logic             active_nxt,
   input  logic [WIDTH-1:0] div_cur,
   input  logic [WIDTH-1:0] div_nxt,
   output logic             tick,
   output logic             div_out
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;
   logic [WIDTH-1:0] high_nxt;

   assign tick = active && (cnt == div_cur - WIDTH'(1));

   // Counting restarts from 0 both on wrap and when leaving IDLE.
   always_comb begin
      cnt_nxt = '0;
      if (active_nxt && active && !tick) begin
         cnt_nxt = cnt + WIDTH'(1);
      end
   end

   // High phase length uses the divisor of the period being entered, so a
   // divisor switched at the period boundary shapes the new period only.
   assign high_nxt = div_nxt - (div_nxt >> 1);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt     <= '0;
         div_out <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         div_out <= active_nxt && (cnt_nxt < high_nxt);
      end
   end

endmodule

// File: rtl/prog_clk_div.sv
// prog_clk_div
//   Programmable clock divider with a glitch-free registered output and a
//   divisor load port that only changes N on period boundaries.
// Ports:
//   clk_in      in   clock, all state updates on the rising edge
//   rst_in      in   asynchronous active-high reset
//   enable      in   level request for the divided clock to run
//   load_valid  in   new divisor offered on load_div
//   load_div    in   requested divisor N (values below 2 are clamped to 2)
//   load_ready  out  a new divisor can be accepted
//   div_out     out  registered divided square wave
//   tick        out  one-cycle pulse on the last cycle of each period
//   running     out  FSM in RUN or DRAIN
//   cur_div     out  divisor currently in effect
//   state_dbg   out  FSM state, for observation only
//
// Load handshake: a divisor transfers on a rising edge where load_valid and
// load_ready are both high. The source holds load_valid and load_div stable
// until that edge; load_valid while load_ready is low is ignored. In IDLE the
// value takes effect at once; while running it waits in a pending register
// (load_ready low) and is applied at the next period end. A transfer on the
// period-end cycle itself bypasses the pending register.
module prog_clk_div
   import clk_div_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int RESET_DIV = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             enable,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_div,
   output logic             load_ready,
   output logic             div_out,
   output logic             tick,
   output logic             running,
   output logic [WIDTH-1:0] cur_div,
   output state_t           state_dbg
);

   localparam logic [WIDTH-1:0] RST_DIV =
      (RESET_DIV < MIN_DIV) ? WIDTH'(MIN_DIV) : WIDTH'(RESET_DIV);

   state_t           state;
   state_t           state_nxt;
   logic             pend_valid;
   logic [WIDTH-1:0] pend_div;
   logic [WIDTH-1:0] cur_div_nxt;
   logic [WIDTH-1:0] load_clamped;
   logic             accept;

   assign load_ready   = !pend_valid;
   assign accept       = load_valid && load_ready;
   assign load_clamped = (load_div < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : load_div;
   assign running      = (state != IDLE);
   assign state_dbg    = state;

   // DRAIN keeps counting so a dropped enable never truncates a period; a
   // re-asserted enable returns to RUN without restarting the count.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = RUN;
         RUN:     if (!enable) state_nxt = DRAIN;
         DRAIN: begin
            if (enable)    state_nxt = RUN;
            else if (tick) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cur_div_nxt = cur_div;
      if (state == IDLE) begin
         if (accept) cur_div_nxt = load_clamped;
      end else if (tick) begin
         if (accept)          cur_div_nxt = load_clamped;
         else if (pend_valid) cur_div_nxt = pend_div;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         cur_div    <= RST_DIV;
         pend_valid <= 1'b0;
         pend_div   <= '0;
      end else begin
         state   <= state_nxt;
         cur_div <= cur_div_nxt;
         if ((state != IDLE) && accept && !tick) begin
            pend_valid <= 1'b1;
            pend_div   <= load_clamped;
         end else if (tick) begin
            pend_valid <= 1'b0;
         end
      end
   end

   clk_div_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .active     (running),
      .active_nxt (state_nxt != IDLE),
      .div_cur    (cur_div),
      .div_nxt    (cur_div_nxt),
      .tick       (tick),
      .div_out    (div_out)
   );

endmodule
